stack_op_sequencer: RTL

Controller that executes stack-machine opcodes on one attached stack instance. It accepts one opcode at a time over a valid/ready handshake and expands it into a micro-sequence of push/pop strobes on the stack. It captures popped operands, computes ALU results and pushes them back. It tracks stack occupancy and rejects any opcode that would underflow or overflow the stack before touching the stack. It sits between instruction decode and the stack datapath.

---
 rtl/stack_op_sequencer_pkg.sv | 40 ++++
 rtl/stack_op_alu.sv | 21 ++
 rtl/stack_op_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/stack_op_sequencer_pkg.sv
// Shared opcode, error and state encodings for the stack opcode sequencer,
// plus the per-opcode stack occupancy requirements.
package stack_op_sequencer_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_POP_A, S_CAP_A, S_POP_B, S_CAP_B, S_EXEC, S_PUSH_1, S_PUSH_2
  } state_e;

  typedef struct packed {
    logic [1:0] pops;
    logic [1:0] pushes;
  } op_needs_t;

  function automatic op_needs_t op_needs(input logic [2:0] op);
    op_needs_t n;
    case (op)
      OP_PUSH: n = '{pops: 2'd0, pushes: 2'd1};
      OP_DROP: n = '{pops: 2'd1, pushes: 2'd0};
      OP_DUP:  n = '{pops: 2'd1, pushes: 2'd2};
      OP_SWAP: n = '{pops: 2'd2, pushes: 2'd2};
      OP_ADD, OP_SUB, OP_AND: n = '{pops: 2'd2, pushes: 2'd1};
      default: n = '{pops: 2'd0, pushes: 2'd0};
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stack_op_alu.sv
// Combinational ALU: B is the second-from-top operand, A the top; results wrap.
module stack_op_alu
  import stack_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    case (op)
      OP_SUB:  r = b - a;
      OP_AND:  r = b & a;
      default: r = b + a;
    endcase
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// Expands one stack-machine opcode into pop/capture/exec/push micro-steps on an
// attached stack, rejecting opcodes that would under/overflow before any strobe.
module stack_op_sequencer
  import stack_op_sequencer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CAPACITY = 3,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_imm,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] count,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_full,
  input  logic             stk_empty
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, din_q, din_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             ready_q, ready_d, push_q, push_d, pop_q, pop_d;
  logic             res_valid_q, res_valid_d, err_q, err_d;
  logic [WIDTH-1:0] alu_r;
  op_needs_t        needs;

  stack_op_alu #(.WIDTH(WIDTH)) u_alu (.op(op_q), .a(a_q), .b(b_q), .r(alu_r));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    din_d       = din_q;
    err_code_d  = err_code_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    needs       = op_needs(op_code);
    count_d     = count_q;
    if (pop_q)       count_d = count_q - CNT_W'(1);
    else if (push_q) count_d = count_q + CNT_W'(1);

    case (state_q)
      S_IDLE: if (op_valid) begin
        op_d = op_code;
        if (int'(count_q) < int'(needs.pops)) begin
          err_d      = 1'b1;
          err_code_d = ERR_UNDER;
        end else if (int'(count_q) - int'(needs.pops) + int'(needs.pushes) > CAPACITY) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVER;
        end else if (op_code == OP_PUSH) begin
          state_d = S_PUSH_1;
          push_d  = 1'b1;
          din_d   = op_imm;
        end else if (op_code != OP_NOP) begin
          state_d = S_POP_A;
          pop_d   = 1'b1;
        end
      end
      S_POP_A: begin
        state_d     = S_CAP_A;
        res_valid_d = (op_q == OP_DROP);
      end
      S_CAP_A: begin
        a_d = stk_dout;
        if (op_q == OP_DROP) begin
          state_d = S_IDLE;
        end else if (op_q == OP_DUP) begin
          state_d = S_PUSH_1;
          push_d  = 1'b1;
          din_d   = stk_dout;
        end else begin
          state_d = S_POP_B;
          pop_d   = 1'b1;
        end
      end
      S_POP_B: state_d = S_CAP_B;
      S_CAP_B: begin
        b_d = stk_dout;
        if (op_q == OP_SWAP) begin
          state_d = S_PUSH_1;
          push_d  = 1'b1;
          din_d   = a_q;
        end else begin
          state_d = S_EXEC;
        end
      end
      // The registered result R lives in the stk_din register for PUSH_1.
      S_EXEC: begin
        state_d = S_PUSH_1;
        push_d  = 1'b1;
        din_d   = alu_r;
      end
      S_PUSH_1: begin
        if (op_q == OP_DUP || op_q == OP_SWAP) begin
          state_d = S_PUSH_2;
          push_d  = 1'b1;
          din_d   = (op_q == OP_DUP) ? a_q : b_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      a_q         <= '0;
      b_q         <= '0;
      din_q       <= '0;
      count_q     <= '0;
      err_code_q  <= ERR_NONE;
      ready_q     <= 1'b1;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      din_q       <= din_d;
      count_q     <= count_d;
      err_code_q  <= err_code_d;
      ready_q     <= ready_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  // The stack presents the popped word during CAP_A, which is the DROP result.
  assign res_data  = res_valid_q ? stk_dout : '0;
  assign op_ready  = ready_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign count     = count_q;
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_din   = din_q;

  a_occupancy_agrees: assert property (@(posedge clk) disable iff (!rst)
    (stk_empty == (count_q == '0)) && (stk_full == (int'(count_q) == CAPACITY)));

endmodule
